mm_sequencer: RTL
=================

Name: mm_sequencer

Overview:
- Matrix-multiply execution unit; sits directly downstream of the instruction decoder and consumes its `operation_en` strobe (opcode 7'b1111111).
- On each accepted strobe it computes C = A x B for fixed-size NxN signed 32-bit matrices held row-major in data memory.
- While running it owns the data-memory port and stalls the CPU PC.
- It drives the stall and releases the pipeline with a one-cycle `done` pulse.

Parameters:
- N, 2, matrix dimension (2..8).
- A_BASE, 32'h0000_0100, byte address of A[0][0].
- B_BASE, 32'h0000_0200, byte address of B[0][0].
- C_BASE, 32'h0000_0300, byte address of C[0][0].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- operation_en  in  1  matrix-op request from the decoder; level, high while the MM instruction is current.
- drdata  in  32  data-memory read data; combinational from daddr in the same cycle.
- daddr  out  32  data-memory byte address (word aligned).
- dwdata  out  32  data-memory write data.
- dwe  out  4  byte write enables; write committed on the clk rising edge.
- busy  out  1  high in every non-IDLE state; the top-level dmem mux selects this block when high.
- stall  out  1  holds the PC and instruction.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE; i=j=k=0; acc=0; a_reg=0.
  - daddr=0, dwdata=0, dwe=0, busy=0, stall=0, done=0.
- Reset asserted mid-operation: abort immediately to IDLE. C words already written stay in memory. No done pulse.
- Index/address arithmetic:
  - Element address = BASE + 4*(row*N+col).
  - Indices are clog2(N)+1 bits wide.
- MAC: acc <= acc + a_reg*drdata, keeping the low 32 bits (two's-complement wrap; no saturation, no overflow flag).
- stall = (state==IDLE && operation_en) || (state not in {IDLE, DONE}). The IDLE term is combinational so the PC never advances past the MM instruction.
- FSM:
  - IDLE: operation_en=1 -> RD_A, clearing i, j, k, acc. Otherwise stay.
  - RD_A: daddr=A_BASE+4*(i*N+k); a_reg<=drdata; -> RD_B.
  - RD_B: daddr=B_BASE+4*(k*N+j); MAC. If k==N-1 then k<=0 and go to WR; else k<=k+1 and go to RD_A.
  - WR: daddr=C_BASE+4*(i*N+j); dwdata=acc; dwe=4'hF; acc<=0.
    - If j<N-1: j++.
    - Else if i<N-1: j<=0, i++.
    - Else -> DONE.
    - If not going to DONE -> RD_A.
  - DONE: done=1, stall=0, busy=1, dwe=0 -> IDLE unconditionally. operation_en is ignored here, so a still-high strobe for the same instruction does not retrigger.
- Outputs in IDLE/DONE: daddr=0, dwdata=0, dwe=0. dwe is nonzero only in WR.
- Latency:
  - Stall spans 1 + N*N*(2N+1) cycles; done follows in the next cycle.
  - For N=2: stall high for 21 cycles, done in cycle 22.
- Back-to-back MM instructions: a new operation_en seen in IDLE (earliest one cycle after DONE) starts a fresh run.
- C is never read during the run. C overlapping A or B is unsupported (results undefined).

Test Plan:
- N=2, A=[1,2;3,4], B=[5,6;7,8], pulse operation_en -> memory at C_BASE..+12 = 19, 22, 43, 50; stall high exactly 21 cycles; done one cycle; dwe=4'hF on exactly 4 cycles.
- A=identity, B=[-3,7;0x7FFFFFFF,-1] -> C equals B bit-exact (signed handling).
- A=[0x10000,0;0,1], B=[0x10000,0;0,0xFFFFFFFF] -> C[0][0]=0 (wrap), C[1][1]=0xFFFFFFFF.
- Assert reset (low) at cycle 12 of a run -> all outputs 0 immediately; C[0][0] and C[0][1] written, C[1][*] untouched; a fresh operation_en afterwards completes correctly.
- Hold operation_en high through DONE and one extra cycle -> exactly one run and one done pulse; then drop it, re-raise -> second full run with identical results.
- operation_en=0 for 50 cycles after reset -> busy, stall, dwe remain 0; daddr=0.

Source files
------------

// File: rtl/mm_sequencer.sv
// Purpose : matrix-multiply sequencer, C = A x B for NxN signed 32-bit
//           row-major matrices in data memory, one word access per cycle.
// Latency : stall held 1 + N*N*(2N+1) cycles, then a one-cycle done pulse.
// Backpr. : none; owns the data-memory port while busy and stalls the CPU
//           PC, so the decoder strobe is the only handshake.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset; aborts a run, no done pulse
//   operation_en level request from the decoder (MM opcode current)
//   drdata       data-memory read data, combinational from daddr
//   daddr        data-memory byte address (word aligned), 0 when idle
//   dwdata       data-memory write data, 0 outside the write state
//   dwe          byte write enables, 4'hF only in the write state
//   busy         high in every non-IDLE state; selects this block on the dmem mux
//   stall        holds PC/instruction while the product is being computed
//   done         one-cycle completion pulse
module mm_sequencer #(
  parameter int unsigned N      = 2,
  parameter logic [31:0] A_BASE = 32'h0000_0100,
  parameter logic [31:0] B_BASE = 32'h0000_0200,
  parameter logic [31:0] C_BASE = 32'h0000_0300
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        operation_en,
  input  logic [31:0] drdata,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dwe,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  // One extra index bit so N itself is representable.
  localparam int IW = $clog2(N) + 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;
  logic [IW-1:0] k_q, k_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   a_reg_q, a_reg_d;

  // Byte address of element [row][col] of a row-major matrix at base.
  function automatic logic [31:0] elem_addr(input logic [31:0]   base,
                                            input logic [IW-1:0] row,
                                            input logic [IW-1:0] col);
    logic [31:0] lin;
    lin = 32'(row) * 32'(N) + 32'(col);
    return base + (lin << 2);
  endfunction

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (operation_en) begin
          state_d = ST_RD_A;
        end
      end
      ST_RD_A: begin
        state_d = ST_RD_B;
      end
      ST_RD_B: begin
        // Last term of the dot product goes straight to the write.
        if (k_q == LAST) begin
          state_d = ST_WR;
        end else begin
          state_d = ST_RD_A;
        end
      end
      ST_WR: begin
        if ((j_q == LAST) && (i_q == LAST)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RD_A;
        end
      end
      // DONE ignores operation_en: the strobe of the instruction that just
      // finished may still be high and must not start a second run.
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: outputs
  //--------------------------------------------------------------------------
  always_comb begin
    daddr  = 32'h0;
    dwdata = 32'h0;
    dwe    = 4'h0;
    busy   = 1'b1;
    stall  = 1'b1;
    done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy  = 1'b0;
        // Combinational so the PC cannot advance past the MM instruction
        // in the cycle the strobe first appears.
        stall = operation_en;
      end
      ST_RD_A: begin
        daddr = elem_addr(A_BASE, i_q, k_q);
      end
      ST_RD_B: begin
        daddr = elem_addr(B_BASE, k_q, j_q);
      end
      ST_WR: begin
        daddr  = elem_addr(C_BASE, i_q, j_q);
        dwdata = acc_q;
        dwe    = 4'hF;
      end
      ST_DONE: begin
        stall = 1'b0;
        done  = 1'b1;
      end
      default: begin
        busy  = 1'b0;
        stall = 1'b0;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Datapath: loop indices, A operand latch and accumulator
  //--------------------------------------------------------------------------
  always_comb begin
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    a_reg_d = a_reg_q;
    case (state_q)
      ST_IDLE: begin
        if (operation_en) begin
          i_d   = '0;
          j_d   = '0;
          k_d   = '0;
          acc_d = 32'h0;
        end
      end
      ST_RD_A: begin
        a_reg_d = drdata;
      end
      ST_RD_B: begin
        // Low 32 bits of the product are identical for signed and unsigned
        // operands, so plain wrap-around arithmetic gives the signed result.
        acc_d = acc_q + a_reg_q * drdata;
        if (k_q == LAST) begin
          k_d = '0;
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      ST_WR: begin
        acc_d = 32'h0;
        if (j_q < LAST) begin
          j_d = j_q + IW'(1);
        end else if (i_q < LAST) begin
          j_d = '0;
          i_d = i_q + IW'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= 32'h0;
      a_reg_q <= 32'h0;
    end else begin
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      a_reg_q <= a_reg_d;
    end
  end

endmodule
